// File: rtl/move_ctrl_timed_if.sv
// Control bundle between the user-input side and the move_ctrl_timed controller.
// master drives the go/stop/pause requests; slave (the controller) drives status.
interface move_ctrl_timed_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             stop;
    logic             pause;
    logic             start;
    logic             move;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] move_count;
    logic             done;
    logic             timeout;

    modport master (
        output go, stop, pause,
        input  start, move, busy, state, move_count, done, timeout
    );

    modport slave (
        input  go, stop, pause,
        output start, move, busy, state, move_count, done, timeout
    );
endinterface

// File: rtl/move_ctrl_timed.sv
// Go/stop motion controller with arm delay, stop hold, pause, saturating move counter and done pulse.
// Optional forced stop after MAX_MOVE move cycles is enabled by defining MOVE_TIMEOUT_EN.
module move_ctrl_timed #(
    parameter int ARM_CYCLES  = 1,
    parameter int STOP_CYCLES = 1,
    parameter int CNT_W       = 16,
    parameter int MAX_MOVE    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    move_ctrl_timed_if.slave    ctrl
);
    typedef enum logic [2:0] {
        READY = 3'd0,
        ARM   = 3'd1,
        MOVE  = 3'd2,
        PAUSE = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int               STOP_EFF  = (STOP_CYCLES < 1) ? 1 : STOP_CYCLES;
    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'((ARM_CYCLES > 0) ? ARM_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_EFF - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] count_inc;
    logic             done_reg, done_next;
    logic             timeout_reg, timeout_next;
    logic             start_reg, move_reg, busy_reg;
    logic             timeout_hit;

    assign count_inc = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);

`ifdef MOVE_TIMEOUT_EN
    // A limit beyond the counter range can never be reached once the counter saturates.
    localparam bit               LIMIT_REACHABLE = (64'(MAX_MOVE) < (64'd1 << CNT_W));
    localparam logic [CNT_W-1:0] MOVE_LIMIT      = CNT_W'(MAX_MOVE);
    assign timeout_hit = LIMIT_REACHABLE && (count_inc >= MOVE_LIMIT);
`else
    logic unused_max_move;
    assign unused_max_move = ^32'(MAX_MOVE);
    assign timeout_hit     = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        count_next   = count_reg;
        done_next    = 1'b0;
        timeout_next = timeout_reg;
        case (state_reg)
            READY: begin
                if (ctrl.go) begin
                    count_next   = '0;
                    timer_next   = '0;
                    timeout_next = 1'b0;
                    state_next   = (ARM_CYCLES == 0) ? MOVE : ARM;
                end
            end
            ARM: begin
                timer_next = '0;
                if (ctrl.stop)
                    state_next = STOP;
                else if (timer_reg == ARM_LAST)
                    state_next = MOVE;
                else
                    timer_next = timer_reg + CNT_W'(1);
            end
            MOVE: begin
                // The current cycle is a MOVE cycle whatever the exit, so it is always counted.
                count_next = count_inc;
                timer_next = '0;
                if (ctrl.stop) begin
                    state_next = STOP;
                end else if (timeout_hit) begin
                    state_next   = STOP;
                    timeout_next = 1'b1;
                end else if (ctrl.pause) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                timer_next = '0;
                if (ctrl.stop)
                    state_next = STOP;
                else if (!ctrl.pause)
                    state_next = MOVE;
            end
            STOP: begin
                if (timer_reg == STOP_LAST) begin
                    state_next = READY;
                    timer_next = '0;
                    done_next  = 1'b1;
                end else begin
                    timer_next = timer_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = READY;
                timer_next = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= READY;
            timer_reg   <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            start_reg   <= 1'b1;
            move_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            start_reg   <= (state_next == READY);
            move_reg    <= (state_next == MOVE);
            busy_reg    <= (state_next != READY);
        end
    end

    assign ctrl.start      = start_reg;
    assign ctrl.move       = move_reg;
    assign ctrl.busy       = busy_reg;
    assign ctrl.state      = state_reg;
    assign ctrl.move_count = count_reg;
    assign ctrl.done       = done_reg;
    assign ctrl.timeout    = timeout_reg;
endmodule
